// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents: the frame FSM state encoding, the parity mode constants, the
// default data width, and a helper that decides whether a received parity
// bit is wrong for the selected mode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned DEFAULT_DATA_BITS = 8;

  // data_xor is the reduction XOR of the data word.
  // Even parity: data and parity together must XOR to 0.
  // Odd parity: they must XOR to 1.
  function automatic logic parity_error(input logic data_xor, input logic par,
                                        input int unsigned mode);
    logic err;
    case (mode)
      PARITY_EVEN: err = data_xor ^ par;
      PARITY_ODD:  err = ~(data_xor ^ par);
      default:     err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Flop-chain synchroniser for an asynchronous serial line.
// All flops reset to 1, which is the idle level of the line.
// Ports:
//   clk_i - sampling clock
//   rst_i - asynchronous, active-high reset
//   d_i   - raw asynchronous input
//   q_o   - d_i delayed by SYNC_STAGES clocks
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain: the new sample enters at bit 0 and leaves at the MSB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer.
// The serial line is synchronised first. The FSM then advances only on bit-centre
// ticks, through start, data (LSB first), optional parity and stop bits.
// Completed frames go into a valid/ready holding register together with
// their error flags.
// Ports:
//   clk_50M    - system clock
//   reset      - asynchronous, active-high reset
//   uart_rxd   - raw serial line, idle high
//   tick       - one-cycle bit-centre strobe
//   data_out   - held data word
//   parity_bit - held received parity bit (0 without parity)
//   data_valid - holding register contains an unread frame
//   data_ready - consumer accepts the held frame
//   parity_err - parity mismatch on the held frame
//   frame_err  - a stop bit of the held frame was sampled low
//   overrun    - one-cycle pulse when a completed frame was dropped
//   busy       - FSM is not idle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int unsigned PARITY_MODE = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  input  logic                 uart_rxd,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_bit,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned      CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  logic rxd_s;
  logic commit_s;
  logic load_s;
  logic ferr_final_s;

  rx_state_e            state_q,    state_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 par_q,      par_d;
  logic                 ferr_acc_q, ferr_acc_d;

  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 par_out_q,  par_out_d;
  logic                 perr_q,     perr_d;
  logic                 ferr_q,     ferr_d;
  logic                 valid_q,    valid_d;
  logic                 overrun_q,  overrun_d;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_50M),
    .rst_i (reset),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  // Frame FSM next-state logic. Nothing advances on non-tick cycles.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ferr_acc_d   = ferr_acc_q;
    commit_s     = 1'b0;
    ferr_final_s = ferr_acc_q | ~rxd_s;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // Low at a bit centre means a start bit. Clear the per-frame state.
          if (!rxd_s) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            par_d      = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          // Right shift, so the first bit received ends up at the LSB.
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          par_d   = rxd_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          ferr_acc_d = ferr_final_s;
          if (stop_cnt_q == LAST_STOP) begin
            commit_s = 1'b1;
            // A low last stop bit may be a break. Wait for the line to
            // return high before accepting another start.
            state_d  = rxd_s ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Holding register next-state logic. If the held frame is accepted in
  // the same cycle as a commit, the new frame replaces it.
  always_comb begin
    load_s     = commit_s & (~valid_q | data_ready);
    data_out_d = data_out_q;
    par_out_d  = par_out_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = commit_s & valid_q & ~data_ready;
    if (load_s) begin
      data_out_d = shift_q;
      par_out_d  = par_q;
      perr_d     = parity_error(^shift_q, par_q, PARITY_MODE);
      ferr_d     = ferr_final_s;
      valid_d    = 1'b1;
    end else if (data_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and holding registers.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_out_q <= '0;
      par_out_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      data_out_q <= data_out_d;
      par_out_q  <= par_out_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign parity_bit = par_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame. It uses three instances:
//   0: 8N1, 2 sync stages
//   1: 8E1, 3 sync stages
//   2: 8N2, 2 sync stages
module tb_uart_rx_frame;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       rxd  [3];
  logic       tck  [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic       pbit [3];
  logic       dval [3];
  logic       perr [3];
  logic       ferr [3];
  logic       ovr  [3];
  logic       bsy  [3];

  int tests = 0;
  int fails = 0;

  uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_n1 (
    .clk_50M(clk), .reset(rst), .uart_rxd(rxd[0]), .tick(tck[0]),
    .data_out(dout[0]), .parity_bit(pbit[0]), .data_valid(dval[0]),
    .data_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .SYNC_STAGES(3)) u_e1 (
    .clk_50M(clk), .reset(rst), .uart_rxd(rxd[1]), .tick(tck[1]),
    .data_out(dout[1]), .parity_bit(pbit[1]), .data_valid(dval[1]),
    .data_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .SYNC_STAGES(2)) u_n2 (
    .clk_50M(clk), .reset(rst), .uart_rxd(rxd[2]), .tick(tck[2]),
    .data_out(dout[2]), .parity_bit(pbit[2]), .data_valid(dval[2]),
    .data_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun(ovr[2]), .busy(bsy[2]));

  typedef struct {
    int         idx;
    logic [7:0] d;
    bit         use_par;
    logic       p;
    int         nstop;
    logic [1:0] stops;   // bit 0 is the first stop bit on the line
    logic [7:0] exp_d;
    logic       exp_pb;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Put one bit on the line. Let it settle through the synchroniser, then
  // give one tick. rp also raises data_ready during the tick cycle.
  // Returns at the negedge right after the tick cycle.
  task automatic send_bit(input int i, input logic b, input bit rp);
    @(negedge clk);
    rxd[i] = b;
    repeat (4) @(negedge clk);
    tck[i] = 1'b1;
    if (rp) rdy[i] = 1'b1;
    @(negedge clk);
    tck[i] = 1'b0;
    if (rp) rdy[i] = 1'b0;
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input bit up, input logic p,
                            input int ns, input logic [1:0] st, input bit rp_last);
    send_bit(i, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send_bit(i, d[k], 1'b0);
    if (up) send_bit(i, p, 1'b0);
    for (int s = 0; s < ns; s++) send_bit(i, st[s], rp_last && (s == ns - 1));
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1, 2'b00, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1, 8'h03, 1'b1, 1'b0, 1, 2'b01, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h03, 1'b1, 1'b1, 1, 2'b01, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h07, 1'b1, 1'b1, 1, 2'b01, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2, 8'h7E, 1'b0, 1'b0, 2, 2'b01, 8'h7E, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{2, 8'h81, 1'b0, 1'b0, 2, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2, 8'h55, 1'b0, 1'b0, 2, 2'b10, 8'h55, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxd[i] = 1'b1;
      tck[i] = 1'b0;
      rdy[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_state", i),
          {8'h00, dout[i], pbit[i], dval[i], perr[i], ferr[i], ovr[i], bsy[i]}, 16'h0000);
    end
    rst = 1'b0;

    // Table-driven frames, consumer always ready.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].idx, vecs[v].d, vecs[v].use_par, vecs[v].p,
                 vecs[v].nstop, vecs[v].stops, 1'b0);
      chk($sformatf("v%0d_valid", v), {15'h0, dval[vecs[v].idx]}, 16'h0001);
      chk($sformatf("v%0d_data", v), {8'h0, dout[vecs[v].idx]}, {8'h0, vecs[v].exp_d});
      chk($sformatf("v%0d_pbit", v), {15'h0, pbit[vecs[v].idx]}, {15'h0, vecs[v].exp_pb});
      chk($sformatf("v%0d_perr", v), {15'h0, perr[vecs[v].idx]}, {15'h0, vecs[v].exp_pe});
      chk($sformatf("v%0d_ferr", v), {15'h0, ferr[vecs[v].idx]}, {15'h0, vecs[v].exp_fe});
      chk($sformatf("v%0d_ovr", v), {15'h0, ovr[vecs[v].idx]}, 16'h0000);
      @(negedge clk);
      chk($sformatf("v%0d_valid_clr", v), {15'h0, dval[vecs[v].idx]}, 16'h0000);
      chk($sformatf("v%0d_data_hold", v), {8'h0, dout[vecs[v].idx]}, {8'h0, vecs[v].exp_d});
      // A high tick releases a line-stuck-low state and is ignored in IDLE.
      send_bit(vecs[v].idx, 1'b1, 1'b0);
      chk($sformatf("v%0d_idle", v), {15'h0, bsy[vecs[v].idx]}, 16'h0000);
    end

    // Break handling: the last stop bit is low and the line stays low.
    send_frame(2, 8'h7E, 1'b0, 1'b0, 2, 2'b01, 1'b0);
    chk("brk_data", {8'h0, dout[2]}, 16'h007E);
    chk("brk_ferr", {15'h0, ferr[2]}, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      send_bit(2, 1'b0, 1'b0);
      chk($sformatf("brk_busy%0d", k), {15'h0, bsy[2]}, 16'h0001);
      chk($sformatf("brk_novalid%0d", k), {15'h0, dval[2]}, 16'h0000);
    end
    send_bit(2, 1'b1, 1'b0);
    chk("brk_release", {15'h0, bsy[2]}, 16'h0000);

    // Overrun: consumer stalled across two frames.
    rdy[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    chk("ovr_first_valid", {15'h0, dval[0]}, 16'h0001);
    chk("ovr_first_data", {8'h0, dout[0]}, 16'h0011);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    chk("ovr_pulse", {15'h0, ovr[0]}, 16'h0001);
    chk("ovr_data_kept", {8'h0, dout[0]}, 16'h0011);
    chk("ovr_valid_kept", {15'h0, dval[0]}, 16'h0001);
    @(negedge clk);
    chk("ovr_pulse_end", {15'h0, ovr[0]}, 16'h0000);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    chk("ovr_accept", {15'h0, dval[0]}, 16'h0000);
    chk("ovr_accept_data", {8'h0, dout[0]}, 16'h0011);

    // Accept in the commit cycle: the new frame replaces the held one.
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    chk("sim_first_valid", {15'h0, dval[0]}, 16'h0001);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b01, 1'b1);
    chk("sim_data", {8'h0, dout[0]}, 16'h0022);
    chk("sim_valid", {15'h0, dval[0]}, 16'h0001);
    chk("sim_no_ovr", {15'h0, ovr[0]}, 16'h0000);
    @(negedge clk);
    chk("sim_valid_held", {15'h0, dval[0]}, 16'h0001);

    // Reset mid-frame: start plus four low data bits of 0xF0.
    for (int k = 0; k < 5; k++) send_bit(0, 1'b0, 1'b0);
    chk("mid_busy", {15'h0, bsy[0]}, 16'h0001);
    rst = 1'b1;
    rxd[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs",
        {8'h00, dout[0], pbit[0], dval[0], perr[0], ferr[0], ovr[0], bsy[0]}, 16'h0000);
    rst = 1'b0;
    // The rest of the aborted frame must not complete anything.
    for (int k = 0; k < 5; k++) send_bit(0, 1'b1, 1'b0);
    chk("mid_no_commit", {15'h0, dval[0]}, 16'h0000);
    chk("mid_idle", {15'h0, bsy[0]}, 16'h0000);
    rdy[0] = 1'b1;
    send_bit(0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send_bit(0, 1'(8'h5A >> k), 1'b0);
    chk("new_pre_stop_valid", {15'h0, dval[0]}, 16'h0000);
    chk("new_pre_stop_data", {8'h0, dout[0]}, 16'h0000);
    send_bit(0, 1'b1, 1'b0);
    chk("new_valid", {15'h0, dval[0]}, 16'h0001);
    chk("new_data", {8'h0, dout[0]}, 16'h005A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
